// File: rtl/multicycle_control_unit.sv
// Multicycle RV32I control FSM: sequences fetch/decode/execute/memory/writeback,
// stalls on the shared-memory ready handshake, resolves branches from ALU flags
// and parks in a sticky fault state on an unsupported opcode or branch funct3.
module multicycle_control_unit #(
    parameter int unsigned ALU_CTRL_W  = 3,
    parameter bit          UNSIGNED_BR = 1'b1
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [6:0]            i_op,
    input  logic [2:0]            i_funct3,
    input  logic                  i_funct7b5,
    input  logic                  i_zero,
    input  logic                  i_neg,
    input  logic                  i_ovf,
    input  logic                  i_carry,
    input  logic                  i_mem_ready,
    output logic                  o_pc_write,
    output logic                  o_ir_write,
    output logic                  o_reg_write,
    output logic                  o_mem_write,
    output logic                  o_mem_req,
    output logic                  o_adr_src,
    output logic [1:0]            o_alu_src_a,
    output logic [1:0]            o_alu_src_b,
    output logic [1:0]            o_result_src,
    output logic [1:0]            o_imm_src,
    output logic [ALU_CTRL_W-1:0] o_alu_control,
    output logic                  o_load,
    output logic                  o_illegal
);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b101;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXEC_R   = 4'd6,
        S_EXEC_I   = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_FAULT    = 4'd11
    } state_t;

    state_t     r_state;
    state_t     w_next;

    logic       w_br_legal;
    logic       w_br_take;
    logic [1:0] w_alu_op;
    logic [2:0] w_alu_ctrl;

    logic       w_pc_write;
    logic       w_ir_write;
    logic       w_reg_write;
    logic       w_mem_write;
    logic       w_mem_req;
    logic       w_adr_src;
    logic [1:0] w_alu_src_a;
    logic [1:0] w_alu_src_b;
    logic [1:0] w_result_src;
    logic [1:0] w_imm_src;
    logic       w_load;
    logic       w_illegal;

    // State register; reset returns straight to instruction fetch.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    // Branch condition from the flags of the rs1 - rs2 subtraction.
    always_comb begin
        w_br_legal = 1'b1;
        w_br_take  = 1'b0;
        case (i_funct3)
            3'b000:  w_br_take = i_zero;
            3'b001:  w_br_take = ~i_zero;
            3'b100:  w_br_take = i_neg ^ i_ovf;
            3'b101:  w_br_take = ~(i_neg ^ i_ovf);
            3'b110: begin
                w_br_legal = UNSIGNED_BR;
                w_br_take  = ~i_carry;
            end
            3'b111: begin
                w_br_legal = UNSIGNED_BR;
                w_br_take  = i_carry;
            end
            default: w_br_legal = 1'b0;
        endcase
    end

    // Next-state and per-state datapath controls.
    always_comb begin
        w_next       = r_state;
        w_pc_write   = 1'b0;
        w_ir_write   = 1'b0;
        w_reg_write  = 1'b0;
        w_mem_write  = 1'b0;
        w_mem_req    = 1'b0;
        w_adr_src    = 1'b0;
        w_alu_src_a  = 2'b00;
        w_alu_src_b  = 2'b00;
        w_result_src = 2'b00;
        w_imm_src    = 2'b00;
        w_alu_op     = 2'b00;
        w_load       = 1'b0;
        w_illegal    = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_mem_req    = 1'b1;
                w_ir_write   = i_mem_ready;
                w_pc_write   = i_mem_ready;
                w_alu_src_b  = 2'b10;
                w_result_src = 2'b10;
                if (i_mem_ready) begin
                    w_next = S_DECODE;
                end
            end
            S_DECODE: begin
                // Speculatively form the branch/jump target from the old PC.
                w_alu_src_a = 2'b01;
                w_alu_src_b = 2'b01;
                w_imm_src   = (i_op == OP_JAL) ? 2'b11 : 2'b10;
                case (i_op)
                    OP_LOAD, OP_STORE: w_next = S_MEMADR;
                    OP_RTYPE:          w_next = S_EXEC_R;
                    OP_ITYPE:          w_next = S_EXEC_I;
                    OP_BRANCH:         w_next = S_BRANCH;
                    OP_JAL:            w_next = S_JAL;
                    default:           w_next = S_FAULT;
                endcase
            end
            S_MEMADR: begin
                w_alu_src_a = 2'b10;
                w_alu_src_b = 2'b01;
                w_imm_src   = i_op[5] ? 2'b01 : 2'b00;
                w_next      = i_op[5] ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                w_mem_req = 1'b1;
                w_adr_src = 1'b1;
                if (i_mem_ready) begin
                    w_next = S_MEMWB;
                end
            end
            S_MEMWB: begin
                w_reg_write  = 1'b1;
                w_result_src = 2'b01;
                w_load       = 1'b1;
                w_next       = S_FETCH;
            end
            S_MEMWRITE: begin
                w_mem_req   = 1'b1;
                w_mem_write = 1'b1;
                w_adr_src   = 1'b1;
                if (i_mem_ready) begin
                    w_next = S_FETCH;
                end
            end
            S_EXEC_R: begin
                w_alu_src_a = 2'b10;
                w_alu_op    = 2'b10;
                w_next      = S_ALUWB;
            end
            S_EXEC_I: begin
                w_alu_src_a = 2'b10;
                w_alu_src_b = 2'b01;
                w_alu_op    = 2'b10;
                w_next      = S_ALUWB;
            end
            S_ALUWB: begin
                w_reg_write = 1'b1;
                w_next      = S_FETCH;
            end
            S_BRANCH: begin
                w_alu_src_a = 2'b10;
                w_alu_op    = 2'b01;
                w_pc_write  = w_br_legal & w_br_take;
                w_next      = w_br_legal ? S_FETCH : S_FAULT;
            end
            S_JAL: begin
                // PC takes the target; PC+4 is written to rd in ALUWB.
                w_alu_src_a = 2'b01;
                w_alu_src_b = 2'b10;
                w_pc_write  = 1'b1;
                w_next      = S_ALUWB;
            end
            S_FAULT: begin
                w_illegal = 1'b1;
            end
            default: w_next = S_FETCH;
        endcase
    end

    // ALU operation from ALUOp and the instruction funct fields.
    always_comb begin
        w_alu_ctrl = ALU_ADD;
        case (w_alu_op)
            2'b01: w_alu_ctrl = ALU_SUB;
            2'b10: begin
                case (i_funct3)
                    3'b000:  w_alu_ctrl = (i_op[5] & i_funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b010:  w_alu_ctrl = ALU_SLT;
                    3'b100:  w_alu_ctrl = ALU_XOR;
                    3'b110:  w_alu_ctrl = ALU_OR;
                    3'b111:  w_alu_ctrl = ALU_AND;
                    default: w_alu_ctrl = ALU_ADD;
                endcase
            end
            default: w_alu_ctrl = ALU_ADD;
        endcase
    end

    // Outputs forced idle while reset is held so no write can complete.
    always_comb begin
        o_pc_write    = i_rst_n & w_pc_write;
        o_ir_write    = i_rst_n & w_ir_write;
        o_reg_write   = i_rst_n & w_reg_write;
        o_mem_write   = i_rst_n & w_mem_write;
        o_mem_req     = i_rst_n & w_mem_req;
        o_adr_src     = i_rst_n & w_adr_src;
        o_alu_src_a   = i_rst_n ? w_alu_src_a  : 2'b00;
        o_alu_src_b   = i_rst_n ? w_alu_src_b  : 2'b00;
        o_result_src  = i_rst_n ? w_result_src : 2'b00;
        o_imm_src     = i_rst_n ? w_imm_src    : 2'b00;
        o_alu_control = i_rst_n ? ALU_CTRL_W'(w_alu_ctrl) : '0;
        o_load        = i_rst_n & w_load;
        o_illegal     = i_rst_n & w_illegal;
    end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed table-driven bench for multicycle_control_unit, plus hand sequences
// for the UNSIGNED_BR=0 variant and reset asserted inside a store.
module tb_multicycle_control_unit;

    typedef struct packed {
        logic       pc;
        logic       ir;
        logic       rw;
        logic       mw;
        logic       mr;
        logic       adr;
        logic [1:0] a;
        logic [1:0] b;
        logic [1:0] rs;
        logic [1:0] imm;
        logic [2:0] alu;
        logic       ld;
        logic       ill;
    } outs_t;

    typedef struct {
        string      name;
        logic       rst;
        logic [6:0] op;
        logic [2:0] f3;
        logic       f7;
        logic [3:0] fl;
        logic       rdy;
        outs_t      exp;
    } vec_t;

    localparam logic [6:0] R   = 7'b0110011;
    localparam logic [6:0] I   = 7'b0010011;
    localparam logic [6:0] LD  = 7'b0000011;
    localparam logic [6:0] ST  = 7'b0100011;
    localparam logic [6:0] BR  = 7'b1100011;
    localparam logic [6:0] J   = 7'b1101111;
    localparam logic [6:0] BAD = 7'h7F;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] op = '0;
    logic [2:0] funct3 = '0;
    logic       funct7b5 = 1'b0;
    logic       zero = 1'b0, neg = 1'b0, ovf = 1'b0, carry = 1'b0;
    logic       mem_ready = 1'b0;

    logic       pc1, ir1, rw1, mw1, mr1, adr1, ld1, ill1;
    logic [1:0] a1, b1, rs1, imm1;
    logic [2:0] alu1;
    logic       pc2, ir2, rw2, mw2, mr2, adr2, ld2, ill2;
    logic [1:0] a2, b2, rs2, imm2;
    logic [2:0] alu2;
    outs_t      act1, act2;

    int n_cmp = 0;
    int n_bad = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    multicycle_control_unit #(.ALU_CTRL_W(3), .UNSIGNED_BR(1'b1)) u_dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_op(op), .i_funct3(funct3), .i_funct7b5(funct7b5),
        .i_zero(zero), .i_neg(neg), .i_ovf(ovf), .i_carry(carry), .i_mem_ready(mem_ready),
        .o_pc_write(pc1), .o_ir_write(ir1), .o_reg_write(rw1), .o_mem_write(mw1),
        .o_mem_req(mr1), .o_adr_src(adr1), .o_alu_src_a(a1), .o_alu_src_b(b1),
        .o_result_src(rs1), .o_imm_src(imm1), .o_alu_control(alu1), .o_load(ld1),
        .o_illegal(ill1)
    );

    multicycle_control_unit #(.ALU_CTRL_W(3), .UNSIGNED_BR(1'b0)) u_dut_nu (
        .i_clk(clk), .i_rst_n(rst_n), .i_op(op), .i_funct3(funct3), .i_funct7b5(funct7b5),
        .i_zero(zero), .i_neg(neg), .i_ovf(ovf), .i_carry(carry), .i_mem_ready(mem_ready),
        .o_pc_write(pc2), .o_ir_write(ir2), .o_reg_write(rw2), .o_mem_write(mw2),
        .o_mem_req(mr2), .o_adr_src(adr2), .o_alu_src_a(a2), .o_alu_src_b(b2),
        .o_result_src(rs2), .o_imm_src(imm2), .o_alu_control(alu2), .o_load(ld2),
        .o_illegal(ill2)
    );

    assign act1 = {pc1, ir1, rw1, mw1, mr1, adr1, a1, b1, rs1, imm1, alu1, ld1, ill1};
    assign act2 = {pc2, ir2, rw2, mw2, mr2, adr2, a2, b2, rs2, imm2, alu2, ld2, ill2};

    function automatic outs_t mk(logic pc, logic ir, logic rw, logic mw, logic mr, logic adr,
                                 logic [1:0] a, logic [1:0] b, logic [1:0] rs,
                                 logic [1:0] imm, logic [2:0] alu, logic ld, logic ill);
        outs_t o;
        o.pc = pc; o.ir = ir; o.rw = rw; o.mw = mw; o.mr = mr; o.adr = adr;
        o.a = a; o.b = b; o.rs = rs; o.imm = imm; o.alu = alu; o.ld = ld; o.ill = ill;
        return o;
    endfunction

    // Expected control words per state, written straight from the state table.
    function automatic outs_t e_zero();  return mk(0,0,0,0,0,0,2'b00,2'b00,2'b00,2'b00,3'b000,0,0); endfunction
    function automatic outs_t e_fetch(logic r); return mk(r,r,0,0,1,0,2'b00,2'b10,2'b10,2'b00,3'b000,0,0); endfunction
    function automatic outs_t e_dec();   return mk(0,0,0,0,0,0,2'b01,2'b01,2'b00,2'b10,3'b000,0,0); endfunction
    function automatic outs_t e_decj();  return mk(0,0,0,0,0,0,2'b01,2'b01,2'b00,2'b11,3'b000,0,0); endfunction
    function automatic outs_t e_exr(logic [2:0] alu); return mk(0,0,0,0,0,0,2'b10,2'b00,2'b00,2'b00,alu,0,0); endfunction
    function automatic outs_t e_exi();   return mk(0,0,0,0,0,0,2'b10,2'b01,2'b00,2'b00,3'b000,0,0); endfunction
    function automatic outs_t e_aluwb(); return mk(0,0,1,0,0,0,2'b00,2'b00,2'b00,2'b00,3'b000,0,0); endfunction
    function automatic outs_t e_madr(logic [1:0] imm); return mk(0,0,0,0,0,0,2'b10,2'b01,2'b00,imm,3'b000,0,0); endfunction
    function automatic outs_t e_mrd();   return mk(0,0,0,0,1,1,2'b00,2'b00,2'b00,2'b00,3'b000,0,0); endfunction
    function automatic outs_t e_mwb();   return mk(0,0,1,0,0,0,2'b00,2'b00,2'b01,2'b00,3'b000,1,0); endfunction
    function automatic outs_t e_mwr();   return mk(0,0,0,1,1,1,2'b00,2'b00,2'b00,2'b00,3'b000,0,0); endfunction
    function automatic outs_t e_br(logic t); return mk(t,0,0,0,0,0,2'b10,2'b00,2'b00,2'b00,3'b001,0,0); endfunction
    function automatic outs_t e_jal();   return mk(1,0,0,0,0,0,2'b01,2'b10,2'b00,2'b00,3'b000,0,0); endfunction
    function automatic outs_t e_fault(); return mk(0,0,0,0,0,0,2'b00,2'b00,2'b00,2'b00,3'b000,0,1); endfunction

    task automatic add(string nm, logic rst, logic [6:0] o, logic [2:0] f3, logic f7,
                       logic [3:0] fl, logic rdy, outs_t e);
        vec_t v;
        v.name = nm; v.rst = rst; v.op = o; v.f3 = f3; v.f7 = f7; v.fl = fl; v.rdy = rdy; v.exp = e;
        vecs.push_back(v);
    endtask

    // R-type instruction with zero-wait fetch: FETCH, DECODE, EXEC_R, ALUWB.
    task automatic add_r(string nm, logic [2:0] f3, logic f7, logic [2:0] alu);
        add({nm, "_fetch"}, 1, R, f3, f7, 4'h0, 1, e_fetch(1));
        add({nm, "_dec"},   1, R, f3, f7, 4'h0, 1, e_dec());
        add({nm, "_exec"},  1, R, f3, f7, 4'h0, 1, e_exr(alu));
        add({nm, "_wb"},    1, R, f3, f7, 4'h0, 1, e_aluwb());
    endtask

    // Branch with flags {zero,neg,ovf,carry}: FETCH, DECODE, BRANCH.
    task automatic add_b(string nm, logic [2:0] f3, logic [3:0] fl, logic take);
        add({nm, "_fetch"}, 1, BR, f3, 0, fl, 1, e_fetch(1));
        add({nm, "_dec"},   1, BR, f3, 0, fl, 1, e_dec());
        add({nm, "_br"},    1, BR, f3, 0, fl, 1, e_br(take));
    endtask

    task automatic step(logic rst, logic [6:0] o, logic [2:0] f3, logic f7,
                        logic [3:0] fl, logic rdy);
        @(negedge clk);
        rst_n = rst; op = o; funct3 = f3; funct7b5 = f7;
        {zero, neg, ovf, carry} = fl; mem_ready = rdy;
        #1;
    endtask

    task automatic chk(string nm, outs_t act, outs_t exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    initial begin
        // Reset and the add x3,x1,x2 walk-through.
        add("rst0", 0, R, 3'b000, 0, 4'h0, 0, e_zero());
        add("rst1", 0, R, 3'b000, 0, 4'hF, 1, e_zero());
        add_r("add", 3'b000, 0, 3'b000);
        add_r("sub", 3'b000, 1, 3'b001);
        add_r("slt", 3'b010, 0, 3'b101);
        add_r("xor", 3'b100, 0, 3'b100);
        add_r("or",  3'b110, 0, 3'b011);
        add_r("and", 3'b111, 1, 3'b010);
        add_r("sll", 3'b001, 0, 3'b000);
        // addi with instruction[30] set must still add.
        add("addi_fetch", 1, I, 3'b000, 1, 4'h0, 1, e_fetch(1));
        add("addi_dec",   1, I, 3'b000, 1, 4'h0, 1, e_dec());
        add("addi_exec",  1, I, 3'b000, 1, 4'h0, 1, e_exi());
        add("addi_wb",    1, I, 3'b000, 1, 4'h0, 1, e_aluwb());
        // lw: one fetch stall, then two MEMREAD wait cycles (7 cycles from accepted fetch).
        add("lw_fwait",  1, LD, 3'b010, 0, 4'h0, 0, e_fetch(0));
        add("lw_fetch",  1, LD, 3'b010, 0, 4'h0, 1, e_fetch(1));
        add("lw_dec",    1, LD, 3'b010, 0, 4'h0, 0, e_dec());
        add("lw_adr",    1, LD, 3'b010, 0, 4'h0, 0, e_madr(2'b00));
        add("lw_rd_w1",  1, LD, 3'b010, 0, 4'h0, 0, e_mrd());
        add("lw_rd_w2",  1, LD, 3'b010, 0, 4'h0, 0, e_mrd());
        add("lw_rd",     1, LD, 3'b010, 0, 4'h0, 1, e_mrd());
        add("lw_wb",     1, LD, 3'b010, 0, 4'h0, 1, e_mwb());
        // sw: mem_write held through the ready cycle, gone the cycle after.
        add("sw_fetch",  1, ST, 3'b010, 0, 4'h0, 1, e_fetch(1));
        add("sw_dec",    1, ST, 3'b010, 0, 4'h0, 1, e_dec());
        add("sw_adr",    1, ST, 3'b010, 0, 4'h0, 1, e_madr(2'b01));
        add("sw_wr_w",   1, ST, 3'b010, 0, 4'h0, 0, e_mwr());
        add("sw_wr",     1, ST, 3'b010, 0, 4'h0, 1, e_mwr());
        add("sw_after",  1, ST, 3'b010, 0, 4'h0, 0, e_fetch(0));
        // Branch sweep, flags are {zero,neg,ovf,carry}.
        add_b("blt",      3'b100, 4'b0100, 1);
        add_b("bge",      3'b101, 4'b0100, 0);
        add_b("blt_ovf",  3'b100, 4'b0110, 0);
        add_b("bltu",     3'b110, 4'b0000, 1);
        add_b("bgeu",     3'b111, 4'b0000, 0);
        add_b("bgeu_c",   3'b111, 4'b0001, 1);
        add_b("beq",      3'b000, 4'b1000, 1);
        add_b("bne",      3'b001, 4'b1000, 0);
        // jal: target imm in DECODE, PC+4 written back in ALUWB.
        add("jal_fetch", 1, J, 3'b000, 0, 4'h0, 1, e_fetch(1));
        add("jal_dec",   1, J, 3'b000, 0, 4'h0, 1, e_decj());
        add("jal_pc",    1, J, 3'b000, 0, 4'h0, 1, e_jal());
        add("jal_wb",    1, J, 3'b000, 0, 4'h0, 1, e_aluwb());
        // Reserved branch funct3 faults without redirecting the PC.
        add_b("b010",     3'b010, 4'b1000, 0);
        add("b010_flt",  1, BR, 3'b010, 0, 4'h0, 1, e_fault());
        add("b010_rst",  0, BR, 3'b010, 0, 4'h0, 1, e_zero());
        // Illegal opcode: sticky for 10 cycles regardless of inputs, cleared by reset.
        add("bad_fetch", 1, BAD, 3'b000, 0, 4'h0, 1, e_fetch(1));
        add("bad_dec",   1, BAD, 3'b000, 0, 4'h0, 1, e_dec());
        for (int i = 0; i < 10; i++) begin
            add("bad_hold", 1, (i % 2 == 0) ? BAD : R, 3'(i), 1'(i), 4'(i), 1'(i), e_fault());
        end
        add("bad_rst",   0, R, 3'b000, 0, 4'h0, 1, e_zero());
        add("bad_rel",   1, R, 3'b000, 0, 4'h0, 0, e_fetch(0));

        foreach (vecs[i]) begin
            step(vecs[i].rst, vecs[i].op, vecs[i].f3, vecs[i].f7, vecs[i].fl, vecs[i].rdy);
            chk(vecs[i].name, act1, vecs[i].exp);
        end

        // UNSIGNED_BR=0 instance treats bltu as a fault; the default instance branches.
        step(0, BR, 3'b110, 0, 4'b0000, 1);
        chk("nu_rst", act2, e_zero());
        step(1, BR, 3'b110, 0, 4'b0000, 1);
        chk("nu_fetch", act2, e_fetch(1));
        step(1, BR, 3'b110, 0, 4'b0000, 1);
        chk("nu_dec", act2, e_dec());
        step(1, BR, 3'b110, 0, 4'b0000, 1);
        chk("nu_br", act2, e_br(0));
        chk("u_br", act1, e_br(1));
        step(1, BR, 3'b110, 0, 4'b0000, 1);
        chk("nu_fault", act2, e_fault());
        chk("u_back", act1, e_fetch(1));

        // Reset dropped in the middle of a MEMWRITE wait cycle.
        step(1, ST, 3'b010, 0, 4'h0, 1);
        chk("rw_dec", act1, e_dec());
        step(1, ST, 3'b010, 0, 4'h0, 0);
        chk("rw_adr", act1, e_madr(2'b01));
        step(1, ST, 3'b010, 0, 4'h0, 0);
        chk("rw_wr", act1, e_mwr());
        #2 rst_n = 1'b0;
        #1;
        chk("rw_async", act1, e_zero());
        step(0, ST, 3'b010, 0, 4'h0, 1);
        chk("rw_held", act1, e_zero());
        step(1, ST, 3'b010, 0, 4'h0, 0);
        chk("rw_fetch", act1, e_fetch(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
